// File: rtl/matrix_b_loader.sv
// FIFO-buffered burst feeder for the Matrix_B operand store: emits gap-free bursts of COL words.
// Optional completed-burst counter enabled by defining LOADER_BURST_CNT_EN.
module matrix_b_loader #(
    parameter int COL   = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     B_opcode,
    output logic [31:0]              Data_to_B,
    input  logic                     Busy_B,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              burst_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (COL > 1) ? $clog2(COL) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   beat;
    logic [BW-1:0]   beat_nxt;
    logic            push;
    logic            pop;
    logic            clear;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     mem [DEPTH];
    logic            busy_unused;

    assign busy_unused = Busy_B;

    assign in_ready  = (fifo_count < CW'(DEPTH)) && !flush;
    assign push      = in_valid && in_ready;
    assign load_done = (state == S_DONE);

    // Each pop happens on the edge that enters its beat, so the registered
    // outputs line up with the beat they belong to.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        pop       = 1'b0;
        clear     = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush) begin
                    clear = 1'b1;
                end else if (fifo_count >= CW'(COL)) begin
                    state_nxt = S_BURST;
                    beat_nxt  = '0;
                    pop       = 1'b1;
                end
            end
            S_BURST: begin
                if (beat == BW'(COL - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    beat_nxt = beat + 1'b1;
                    pop      = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            B_opcode  <= 1'b0;
            Data_to_B <= '0;
        end else begin
            B_opcode <= pop;
            if (pop) Data_to_B <= mem[rd_ptr];
        end
    end

`ifdef LOADER_BURST_CNT_EN
    logic [15:0] burst_cnt_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt_r <= '0;
        end else if (state == S_DONE) begin
            burst_cnt_r <= burst_cnt_r + 16'd1;
        end
    end

    assign burst_cnt = burst_cnt_r;
`else
    assign burst_cnt = '0;
`endif

endmodule

// File: tb/tb_matrix_b_loader.sv
// Scoreboard bench for matrix_b_loader: stimulus queues expected words, a monitor checks each beat.
module tb_matrix_b_loader;

    localparam int COL   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        B_opcode;
    logic [31:0] Data_to_B;
    logic        Busy_B = 1'b0;
    logic        load_done;
    logic [3:0]  fifo_count;
    logic [15:0] burst_cnt;

    matrix_b_loader #(.COL(COL), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .B_opcode   (B_opcode),
        .Data_to_B  (Data_to_B),
        .Busy_B     (Busy_B),
        .load_done  (load_done),
        .fifo_count (fifo_count),
        .burst_cnt  (burst_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int          bursts_seen = 0;
    int          bursts_since_rst = 0;
    bit          check_gap = 1'b0;
    bit          seen_prev = 1'b0;
    int          gap = 0;
    int          beats = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input bit expect_out, output bit acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        acc      = in_ready;
        @(posedge clk);
        if (acc && expect_out) exp_q.push_back(d);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || B_opcode || load_done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n >= budget), 1'b0);
    endtask

    // Monitor: every write beat must match the next queued word; a burst must be
    // COL beats long and be followed immediately by load_done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                beats = 0;
                gap = 0;
                seen_prev = 1'b0;
                bursts_since_rst = 0;
            end else if (B_opcode) begin
                if (beats == 0 && check_gap && seen_prev) check("burst_gap", gap, 2);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL data_unexpected: got=%h want=none", Data_to_B);
                end else begin
                    check("data", Data_to_B, exp_q.pop_front());
                end
                beats++;
                gap = 0;
            end else begin
                if (beats > 0) begin
                    check("done_after_burst", load_done, 1'b1);
                    check("burst_len", beats, COL);
                    bursts_seen++;
                    bursts_since_rst++;
                    seen_prev = 1'b1;
                    beats = 0;
                end else if (load_done) begin
                    total++;
                    bad++;
                    $display("FAIL load_done_spurious: got=1 want=0");
                end
                gap++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] t1[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        bit acc;
        bit saw_full;
        int sent;
        int cycles;
        int b0;
        int cnt0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_b_opcode", B_opcode, 1'b0);
        check("rst_data", Data_to_B, 32'h0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_burst_cnt", burst_cnt, 0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        @(negedge clk);
        check("rst_push_ignored", fifo_count, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_count", fifo_count, 0);

        // Basic burst with exact timing
        for (int i = 0; i < 4; i++) push_word(t1[i], 1'b1, acc);
        check("cnt_after_4", fifo_count, 4);
        for (int k = 1; k <= COL; k++) begin
            step();
            check("beat_opcode", B_opcode, 1'b1);
            check("beat_no_done", load_done, 1'b0);
        end
        step();
        check("end_opcode", B_opcode, 1'b0);
        check("end_load_done", load_done, 1'b1);
        step();
        check("idle_opcode", B_opcode, 1'b0);
        check("idle_load_done", load_done, 1'b0);
        check("data_holds", Data_to_B, 32'h44);
        check("cnt_empty", fifo_count, 0);

        // Streaming 1..32 with continuous valid
        b0 = bursts_seen;
        cnt0 = burst_cnt;
        seen_prev = 1'b0;
        check_gap = 1'b1;
        sent = 1;
        cycles = 0;
        saw_full = 1'b0;
        while (sent <= 32 && cycles < 400) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = sent;
            check("ready_vs_count", in_ready, (fifo_count < DEPTH));
            if (!in_ready) saw_full = 1'b1;
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(sent);
                sent++;
            end
            cycles++;
        end
        #1;
        in_valid = 1'b0;
        check("stream_timeout", (cycles >= 400), 1'b0);
        drain(200);
        check_gap = 1'b0;
        check("stream_bursts", bursts_seen - b0, 8);
        check("in_ready_dropped", saw_full, 1'b1);
`ifdef LOADER_BURST_CNT_EN
        check("stream_burst_cnt", 32'(burst_cnt) - 32'(cnt0), 8);
`else
        check("burst_cnt_off", burst_cnt, 0);
`endif

        // Flush in IDLE discards partial data
        b0 = bursts_seen;
        for (int i = 0; i < 3; i++) push_word(32'hA1 + i, 1'b0, acc);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_blocks_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_clears", fifo_count, 0);
        repeat (6) step();
        check("flush_no_burst", bursts_seen - b0, 0);

        // Flush during a burst is ignored
        for (int i = 0; i < 6; i++) push_word(32'hB1 + i, 1'b1, acc);
        step();
        check("cnt_beat2", fifo_count, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        check("flush_ignored_cnt", fifo_count, 2);
        check("flush_burst_done", bursts_seen - b0, 1);
        push_word(32'hB7, 1'b1, acc);
        push_word(32'hB8, 1'b1, acc);
        drain(50);
        check("flush_second_burst", bursts_seen - b0, 2);

        // Reset during the last beat abandons the burst
        for (int i = 0; i < 4; i++) push_word(32'hC1 + i, 1'b1, acc);
        push_word(32'hC5, 1'b0, acc);
        push_word(32'hC6, 1'b0, acc);
        step();
        step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_opcode", B_opcode, 1'b0);
        check("midrst_count", fifo_count, 0);
        check("midrst_data", Data_to_B, 32'h0);
        check("midrst_burst_cnt", burst_cnt, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        b0 = bursts_seen;
        for (int i = 0; i < 4; i++) push_word(32'hD1 + i, 1'b1, acc);
        drain(50);
        check("post_rst_burst", bursts_seen - b0, 1);
        check("post_rst_count", fifo_count, 0);

`ifdef LOADER_BURST_CNT_EN
        check("burst_cnt_after_rst", burst_cnt, bursts_since_rst);
        @(negedge clk);
        force dut.burst_cnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.burst_cnt_r;
        check("burst_cnt_preload", burst_cnt, 32'hFFFF);
        for (int i = 0; i < 4; i++) push_word(32'hE1 + i, 1'b1, acc);
        drain(50);
        check("burst_cnt_wrap", burst_cnt, 0);
`else
        for (int i = 0; i < 4; i++) push_word(32'hE1 + i, 1'b1, acc);
        drain(50);
        check("burst_cnt_stays_0", burst_cnt, 0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
